spi_wb_host: RTL and testbench
==============================

# spi_wb_host

Host-side counterpart of the SPI-to-Wishbone bridge. It accepts single Wishbone transactions and serialises each one into the byte protocol the remote bridge decodes: command, address, data, then stall/ack polling. It drives a byte-level SPI master shifter, which performs one full-duplex byte exchange per request. It returns the remote's read data or completion as a Wishbone acknowledge. It sits between the host-side Wishbone interconnect and the SPI master PHY.

## Interface
Parameters:
- `ACK_BYTE`, default 8'h55: byte value returned by the remote when the transaction has completed.
- `POLL_MAX`, default 255: maximum number of non-ack poll bytes before abort. Used only with `SPI_WB_HOST_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; everything is `posedge clk`.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `wb_stb`  in  1  Wishbone strobe, pipelined mode.
- `wb_we`  in  1  1 = write.
- `wb_sel`  in  4  lane select; forwarded as command bits [3:0].
- `wb_adr`  in  8  address byte.
- `wb_dat_i`  in  8  write data.
- `wb_stall`  out  1  1 while a transaction is in flight.
- `wb_ack`  out  1  one-cycle completion pulse.
- `wb_err`  out  1  one-cycle timeout pulse; tied 0 without the macro.
- `wb_dat_o`  out  8  read data, valid with `wb_ack`.
- `tx_data`  out  8  byte to shift out.
- `tx_stb`  out  1  one-cycle request to start a byte exchange.
- `tx_ready`  in  1  shifter idle and able to accept `tx_stb`.
- `rx_data`  in  8  byte shifted in during the exchange.
- `rx_stb`  in  1  one-cycle pulse when the exchange is finished.

## Operation
- Reset values: `wb_stall`, `wb_ack`, `wb_err`, `tx_stb` = 0. `wb_dat_o`, `tx_data` = 8'h00. Poll counter = 0. State = IDLE.
- Transaction acceptance:
  - A transaction is accepted in IDLE when `wb_stb` = 1. The module latches `we`, `sel`, `adr` and `dat_i`.
  - `wb_stall` goes 1 on the next cycle and stays 1 until the cycle after `wb_ack` or `wb_err`.
- Exchange rule: every protocol byte is one exchange.
  - Issue: `tx_stb` = 1 for one cycle, only when `tx_ready` = 1.
  - Wait: then wait for `rx_stb`.
  - Limit: only one exchange is ever outstanding.
- States and transitions:
  - IDLE: accept a request.
    - `sel` = 0 and read: do not enter CMD. Pulse `wb_ack` with `wb_dat_o` = 0 and generate no link traffic, because a 0x00 command is a no-op at the remote.
    - Otherwise go to CMD.
  - CMD: send {we,3'b000,sel}. On `rx_stb`, go to ADDR.
  - ADDR: send `adr`. On `rx_stb`, go to WDATA if write, POLL if read.
  - WDATA: send `dat_i`. On `rx_stb`, go to POLL.
  - POLL: send 8'h00.
    - On `rx_stb` with `rx_data` == `ACK_BYTE`: go to RDATA if read. If write, pulse `wb_ack` and go to IDLE.
    - On any other `rx_data`: increment the poll counter and send another poll byte.
  - RDATA: send 8'h00. On `rx_stb`, latch `rx_data` into `wb_dat_o`, pulse `wb_ack`, go to IDLE.
- Discarded bytes: received bytes in CMD, ADDR and WDATA are ignored.
- Poll counter: clears on entry to CMD. It is 8 bits wide and saturates at `POLL_MAX`.
- `rx_stb` while no exchange is outstanding: ignored.
- `wb_stb` while `wb_stall` = 1: ignored and not queued.
- Reset mid-transaction: returns to IDLE at once, with no ack and no err. Any exchange in flight is abandoned. The remote resynchronises because its idle state skips 0x00 bytes; software re-issues the transaction.

## Timing
- Byte issue: `tx_stb` is asserted the first cycle the state needs a byte and `tx_ready` = 1. This is the same cycle as the state entry if `tx_ready` is already 1.
- Next state: the state advances in the cycle after the `rx_stb` pulse. The next `tx_stb` can follow in that same cycle.
- Latency, excluding exchange time: each byte adds 1 cycle of issue plus the shifter's exchange time.
  - Write minimum: 4 exchanges (cmd, adr, dat, ack poll).
  - Read minimum: 4 exchanges (cmd, adr, ack poll, data).
- Ack: `wb_ack` fires 1 cycle after the final `rx_stb`. `wb_stall` drops 1 cycle later.
- Output hold: `wb_dat_o` holds its value until the next read completes.

## Configuration
- `SPI_WB_HOST_TIMEOUT_EN` defined:
  - In POLL, once the poll counter equals `POLL_MAX`, a further non-ack byte ends the transaction.
  - The module pulses `wb_err` for 1 cycle (no `wb_ack`) and returns to IDLE.
- Not defined: POLL repeats forever, `wb_err` is constant 0, and there is no counter logic.

## Test plan
- Write, sel=4'h1, adr=8'h03, dat=8'hA5; remote returns 00,00,00,00,55 -> tx bytes 81,03,A5,00,00; `wb_ack` once; `wb_err` 0.
- Read, sel=4'h1, adr=8'h07; remote returns 00,00,55 then data 8'h3C -> tx bytes 01,07,00,00; `wb_ack` with `wb_dat_o` = 8'h3C.
- Read with sel=0 -> `wb_ack` the cycle after acceptance, `wb_dat_o` = 0, `tx_stb` never asserted.
- `tx_ready` held 0 for 10 cycles while in CMD -> `tx_stb` stays 0, then pulses once when `tx_ready` rises; `wb_stb` presented during the stall is ignored.
- With the macro and POLL_MAX=3, remote never returns 55 -> exactly 4 poll bytes, `wb_err` pulse, no `wb_ack`, IDLE.
- `rst_n` low mid-POLL -> all outputs go to reset values immediately; the next read completes normally.

Source files
------------

// File: rtl/spi_wb_host_if.sv
// Host-side Wishbone (pipelined) port bundle for spi_wb_host.
// The master modport is the interconnect side, the slave modport is the bridge host.
interface spi_wb_host_if;
  logic       wb_stb;
  logic       wb_we;
  logic [3:0] wb_sel;
  logic [7:0] wb_adr;
  logic [7:0] wb_dat_i;
  logic       wb_stall;
  logic       wb_ack;
  logic       wb_err;
  logic [7:0] wb_dat_o;

  modport master (
    output wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
    input  wb_stall, wb_ack, wb_err, wb_dat_o
  );

  modport slave (
    input  wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
    output wb_stall, wb_ack, wb_err, wb_dat_o
  );
endinterface

// File: rtl/spi_wb_host.sv
// Serialises single Wishbone transactions into cmd/addr/data/poll bytes for a byte SPI master.
// Optional poll timeout with wb_err is enabled by defining SPI_WB_HOST_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for wb_stb; sel=0 reads complete here with no link traffic
// CMD   | exchanging {we,3'b000,sel}
// ADDR  | exchanging the address byte
// WDATA | exchanging the write data byte
// POLL  | exchanging 0x00 until the remote answers ACK_BYTE
// RDATA | exchanging 0x00 to fetch the read data
module spi_wb_host #(
  parameter logic [7:0] ACK_BYTE = 8'h55,
  parameter int         POLL_MAX = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_wb_host_if.slave      wb,
  output logic [7:0]        tx_data,
  output logic              tx_stb,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_stb
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, POLL, RDATA} state_t;

  state_t     state, state_next;
  logic       pending;
  logic       we_q;
  logic [3:0] sel_q;
  logic [7:0] adr_q, dat_q;
  logic       stall_q, stall_next;
  logic       ack_q, ack_next;
  logic [7:0] dat_o_q, dat_o_next;
  logic       need_byte;
  logic       accept;
  logic       rx_done;

`ifdef SPI_WB_HOST_TIMEOUT_EN
  localparam logic [7:0] POLL_LIMIT = POLL_MAX[7:0];
  logic [7:0] poll_cnt;
  logic       err_q, err_next;
`endif

  assign accept  = (state == IDLE) && wb.wb_stb && !stall_q;
  // rx_stb only counts when we actually have a byte in flight
  assign rx_done = rx_stb && pending;

  always_comb begin
    state_next = state;
    stall_next = stall_q;
    ack_next   = 1'b0;
    dat_o_next = dat_o_q;
    tx_data    = 8'h00;
    need_byte  = 1'b0;
`ifdef SPI_WB_HOST_TIMEOUT_EN
    err_next   = 1'b0;
    if (ack_q || err_q) stall_next = 1'b0;
`else
    if (ack_q) stall_next = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          stall_next = 1'b1;
          if (!wb.wb_we && (wb.wb_sel == 4'h0)) begin
            ack_next   = 1'b1;
            dat_o_next = 8'h00;
          end else begin
            state_next = CMD;
          end
        end
      end
      CMD: begin
        tx_data   = {we_q, 3'b000, sel_q};
        need_byte = 1'b1;
        if (rx_done) state_next = ADDR;
      end
      ADDR: begin
        tx_data   = adr_q;
        need_byte = 1'b1;
        if (rx_done) state_next = we_q ? WDATA : POLL;
      end
      WDATA: begin
        tx_data   = dat_q;
        need_byte = 1'b1;
        if (rx_done) state_next = POLL;
      end
      POLL: begin
        need_byte = 1'b1;
        if (rx_done) begin
          if (rx_data == ACK_BYTE) begin
            if (we_q) begin
              ack_next   = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = RDATA;
            end
          end
`ifdef SPI_WB_HOST_TIMEOUT_EN
          else if (poll_cnt == POLL_LIMIT) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end
`endif
        end
      end
      RDATA: begin
        need_byte = 1'b1;
        if (rx_done) begin
          dat_o_next = rx_data;
          ack_next   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    tx_stb = need_byte && !pending && tx_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= 1'b0;
      stall_q <= 1'b0;
      ack_q   <= 1'b0;
      dat_o_q <= 8'h00;
    end else begin
      state   <= state_next;
      stall_q <= stall_next;
      ack_q   <= ack_next;
      dat_o_q <= dat_o_next;
      if (tx_stb)       pending <= 1'b1;
      else if (rx_done) pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q  <= 1'b0;
      sel_q <= 4'h0;
      adr_q <= 8'h00;
      dat_q <= 8'h00;
    end else if (accept) begin
      we_q  <= wb.wb_we;
      sel_q <= wb.wb_sel;
      adr_q <= wb.wb_adr;
      dat_q <= wb.wb_dat_i;
    end
  end

`ifdef SPI_WB_HOST_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_cnt <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_next;
      if (accept)
        poll_cnt <= 8'h00;
      else if ((state == POLL) && rx_done && (rx_data != ACK_BYTE) && (poll_cnt != POLL_LIMIT))
        poll_cnt <= poll_cnt + 8'd1;
    end
  end
  assign wb.wb_err = err_q;
`else
  assign wb.wb_err = 1'b0;
`endif

  assign wb.wb_stall = stall_q;
  assign wb.wb_ack   = ack_q;
  assign wb.wb_dat_o = dat_o_q;

endmodule

// File: tb/tb_spi_wb_host.sv
// Scoreboard bench for spi_wb_host: a behavioural byte shifter answers each exchange
// from a response queue; expected tx bytes and Wishbone results are queued per transaction.
module tb_spi_wb_host;

  typedef struct {
    logic       is_err;
    logic [7:0] dat;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data;
  logic       tx_stb;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_stb;
  logic       ready_en = 1'b1;
  logic       sh_busy = 1'b0;
  logic       filler_ok = 1'b0;
  logic [7:0] last_rd = 8'h00;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exch_cnt = 0;
  int n_done = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] resp_q[$];
  res_t       exp_res[$];

  always #5 clk = ~clk;

  assign tx_ready = ready_en && !sh_busy;

  spi_wb_host_if bus();

  spi_wb_host #(.ACK_BYTE(8'h55), .POLL_MAX(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb       (bus),
    .tx_data  (tx_data),
    .tx_stb   (tx_stb),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_stb   (rx_stb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // byte shifter model: fixed exchange time, answers from resp_q
  initial begin
    bit skip = 1'b0;
    rx_stb  = 1'b0;
    rx_data = 8'h00;
    forever begin
      if (skip) #1;
      else begin
        @(posedge clk);
        #2;
      end
      skip = 1'b0;
      if (rst_n && tx_stb) begin
        exch_cnt++;
        chk("stb_noready", tx_ready, 1);
        if (exp_tx.size() > 0) chk("tx_byte", tx_data, exp_tx.pop_front());
        else if (filler_ok)    chk("tx_poll", tx_data, 8'h00);
        else                   chk("tx_unexp", tx_stb, 0);
        @(posedge clk);
        #1 sh_busy = 1'b1;
        chk("stb_single", tx_stb, 0);
        repeat (2) @(posedge clk);
        #1;
        if (rst_n && resp_q.size() > 0) rx_data = resp_q.pop_front();
        else rx_data = 8'h00;
        rx_stb = 1'b1;
        @(posedge clk);
        #1;
        rx_stb  = 1'b0;
        sh_busy = 1'b0;
        skip    = 1'b1;
      end
    end
  end

  // Wishbone result monitor
  initial begin
    bit   prev = 1'b0;
    res_t r;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) prev = 1'b0;
      else begin
        if (prev) chk("stall_drop", bus.wb_stall, 0);
        prev = bus.wb_ack || bus.wb_err;
        if (prev) begin
          done_cnt++;
          chk("stall_at_done", bus.wb_stall, 1);
          if (exp_res.size() > 0) begin
            r = exp_res.pop_front();
            chk("ack", bus.wb_ack, !r.is_err);
            chk("err", bus.wb_err, r.is_err);
            chk("dat_o", bus.wb_dat_o, r.dat);
          end else begin
            chk("done_unexp", prev, 0);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(posedge clk);
    #1;
    while (bus.wb_stall && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", bus.wb_stall, 0);
  endtask

  // npoll = number of poll bytes; last one is the ack unless is_err
  task automatic txn(input logic we, input logic [3:0] sel, input logic [7:0] adr,
                     input logic [7:0] dat, input int npoll, input logic is_err,
                     input logic [7:0] rd);
    res_t r;
    wait_idle();
    if (we || sel != 4'h0) begin
      exp_tx.push_back({we, 3'b000, sel});
      exp_tx.push_back(adr);
      resp_q.push_back(8'h00);
      resp_q.push_back(8'h00);
      if (we) begin
        exp_tx.push_back(dat);
        resp_q.push_back(8'h00);
      end
      for (int i = 0; i < npoll; i++) begin
        exp_tx.push_back(8'h00);
        resp_q.push_back((i == npoll - 1 && !is_err) ? 8'h55 : 8'h00);
      end
      if (!we && !is_err) begin
        exp_tx.push_back(8'h00);
        resp_q.push_back(rd);
      end
    end
    r.is_err = is_err;
    if (we || is_err) r.dat = last_rd;
    else r.dat = (sel == 4'h0) ? 8'h00 : rd;
    last_rd = r.dat;
    exp_res.push_back(r);
    n_done++;
    bus.wb_stb   = 1'b1;
    bus.wb_we    = we;
    bus.wb_sel   = sel;
    bus.wb_adr   = adr;
    bus.wb_dat_i = dat;
    @(posedge clk);
    #1 bus.wb_stb = 1'b0;
    chk("stall_set", bus.wb_stall, 1);
    if (!we && sel == 4'h0) chk("ack_sel0", bus.wb_ack, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt < n_done && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done", done_cnt, n_done);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_stall", bus.wb_stall, 0);
    chk("rst_ack", bus.wb_ack, 0);
    chk("rst_err", bus.wb_err, 0);
    chk("rst_tx_stb", tx_stb, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_dat_o", bus.wb_dat_o, 8'h00);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got %0d exp %0d", done_cnt, n_done);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int base;
    bus.wb_stb   = 1'b0;
    bus.wb_we    = 1'b0;
    bus.wb_sel   = 4'h0;
    bus.wb_adr   = 8'h00;
    bus.wb_dat_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;

    txn(1'b1, 4'h1, 8'h03, 8'hA5, 2, 1'b0, 8'h00);
    wait_done();
    txn(1'b0, 4'h1, 8'h07, 8'h00, 1, 1'b0, 8'h3C);
    wait_done();
    txn(1'b0, 4'h0, 8'h99, 8'h00, 0, 1'b0, 8'h00);
    wait_done();
    txn(1'b1, 4'hC, 8'h11, 8'h22, 3, 1'b0, 8'h00);
    wait_done();

    // shifter not ready: nothing may issue, stray strobe must be dropped
    ready_en = 1'b0;
    txn(1'b1, 4'h3, 8'h20, 8'h5A, 1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      bus.wb_stb = (i == 3);
      bus.wb_we  = 1'b0;
      bus.wb_sel = 4'hF;
      bus.wb_adr = 8'hFF;
      @(posedge clk);
      #1;
      chk("hold_stb", tx_stb, 0);
      chk("hold_stall", bus.wb_stall, 1);
    end
    bus.wb_stb = 1'b0;
    ready_en = 1'b1;
    wait_done();

`ifdef SPI_WB_HOST_TIMEOUT_EN
    txn(1'b1, 4'hF, 8'h10, 8'h20, 4, 1'b1, 8'h00);
    wait_done();
`endif

    txn(1'b0, 4'h8, 8'h5E, 8'h00, 3, 1'b0, 8'hC3);
    wait_done();

    // reset while polling
    wait_idle();
    exp_tx.push_back(8'h01);
    exp_tx.push_back(8'h30);
    resp_q.push_back(8'h00);
    resp_q.push_back(8'h00);
    filler_ok = 1'b1;
    base = exch_cnt;
    bus.wb_stb = 1'b1;
    bus.wb_we  = 1'b0;
    bus.wb_sel = 4'h1;
    bus.wb_adr = 8'h30;
    @(posedge clk);
    #1 bus.wb_stb = 1'b0;
    for (int n = 0; n < 200 && exch_cnt < base + 4; n++) @(posedge clk);
    chk("poll_reached", exch_cnt >= base + 4, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    exp_tx.delete();
    resp_q.delete();
    exp_res.delete();
    filler_ok = 1'b0;
    last_rd = 8'h00;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b1;

    txn(1'b0, 4'h2, 8'h44, 8'h00, 1, 1'b0, 8'h9A);
    wait_done();

    repeat (5) @(posedge clk);
    chk("tx_left", exp_tx.size(), 0);
    chk("res_left", exp_res.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
